// File: rtl/prim_beat_packer_pkg.sv
// Shared types for the narrow-to-wide beat packer.
//   packer_st_e : FILL collects beats, HOLD presents a packed word downstream.
package prim_beat_packer_pkg;

   typedef enum logic [1:0] {
      FILL = 2'b01,
      HOLD = 2'b10
   } packer_st_e;

endpackage

// File: rtl/prim_beat_packer.sv
// Narrow-to-wide packer: gathers Ratio beats of InW bits into one OutW-bit word
// with a per-lane valid mask. A beat marked last flushes a partial word early.
// Lanes not written in a flushed word read as zero.
//
// Ports
//   clk_i, rst_ni     : clock, async active-low reset
//   clr_i             : sync clear, drops any partial or held word
//   in_valid_i/ready_o: input beat handshake; in_data_i beat, in_last_i flush marker
//   out_valid_o/ready_i: packed word handshake (drives a FIFO write port)
//   out_data_o        : packed word, lane 0 = first beat
//   out_mask_o        : per-lane valid bits
//   busy_o            : partial word pending or word held
//
// state | meaning
// FILL  | accepting beats into lane cnt
// HOLD  | word complete, presented on out_*; new beat accepted only on retire
module prim_beat_packer
   import prim_beat_packer_pkg::*;
#(
   parameter  int unsigned InW   = 8,
   parameter  int unsigned Ratio = 4,
   localparam int unsigned OutW  = InW * Ratio,
   localparam int unsigned CntW  = $clog2(Ratio)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [InW-1:0]  in_data_i,
   input  logic            in_last_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [OutW-1:0] out_data_o,
   output logic [Ratio-1:0] out_mask_o,
   output logic            busy_o
);

   if (Ratio < 2) begin : g_ratio_chk
      $error("prim_beat_packer: Ratio must be at least 2");
   end

   packer_st_e       r_st;
   packer_st_e       w_st_nxt;
   logic [CntW-1:0]  r_cnt;
   logic [CntW-1:0]  w_cnt_nxt;
   logic [OutW-1:0]  r_data;
   logic [OutW-1:0]  w_data_nxt;
   logic [Ratio-1:0] r_mask;
   logic [Ratio-1:0] w_mask_nxt;
   logic             r_under_rst;

   logic             w_in_acc;
   logic             w_out_hs;

   // Ready looks straight through to out_ready_i so a retiring word and a new
   // beat can share one cycle, giving full throughput.
   assign in_ready_o  = ~r_under_rst & ((r_st == FILL) | out_ready_i);
   assign out_valid_o = (r_st == HOLD) & ~r_under_rst;
   assign out_data_o  = r_data;
   assign out_mask_o  = r_mask;
   assign busy_o      = (r_st == HOLD) | (|r_mask);

   assign w_in_acc = in_valid_i & in_ready_o;
   assign w_out_hs = out_valid_o & out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_st        <= FILL;
         r_cnt       <= '0;
         r_data      <= '0;
         r_mask      <= '0;
         r_under_rst <= 1'b1;
      end else begin
         r_st        <= w_st_nxt;
         r_cnt       <= w_cnt_nxt;
         r_data      <= w_data_nxt;
         r_mask      <= w_mask_nxt;
         r_under_rst <= 1'b0;
      end
   end

   always_comb begin
      w_st_nxt   = r_st;
      w_cnt_nxt  = r_cnt;
      w_data_nxt = r_data;
      w_mask_nxt = r_mask;
      if (clr_i) begin
         w_st_nxt   = FILL;
         w_cnt_nxt  = '0;
         w_data_nxt = '0;
         w_mask_nxt = '0;
      end else begin
         if (w_out_hs) begin
            w_st_nxt   = FILL;
            w_data_nxt = '0;
            w_mask_nxt = '0;
         end
         // cnt is already 0 whenever HOLD retires, so a beat accepted in the
         // same cycle lands in lane 0 of the freshly cleared word.
         if (w_in_acc) begin
            w_data_nxt[r_cnt*InW +: InW] = in_data_i;
            w_mask_nxt[r_cnt]            = 1'b1;
            if ((r_cnt == CntW'(Ratio - 1)) || in_last_i) begin
               w_st_nxt  = HOLD;
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/prim_beat_packer.md
# prim_beat_packer

Synchronous narrow-to-wide packer that gathers `Ratio` beats of `InW` bits into one `InW*Ratio`-bit word with a per-lane valid mask. It sits directly upstream of the synchronous FIFO primitive (`prim_fifo_sync`) and drives its write port (`wvalid`/`wready`/`wdata`). Partial words can be flushed early with a last marker. Both sides use valid/ready handshakes with full throughput.

## Interface
- `InW`, 8: input beat width in bits.
- `Ratio`, 4: beats per output word; must be ≥ 2 (elaboration-time assertion).
- `OutW`, derived localparam `InW*Ratio`: output word width.
- `CntW`, derived localparam `$clog2(Ratio)`: lane index width.
- `clk_i` in 1: clock; all logic is on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `clr_i` in 1: synchronous clear; discards the partial or held word.
- `in_valid_i` in 1: input beat valid.
- `in_ready_o` out 1: input beat accepted when both valid and ready are high.
- `in_data_i` in InW: beat data.
- `in_last_i` in 1: final beat of a word; forces a flush of the partial word.
- `out_valid_o` out 1: packed word valid.
- `out_ready_i` in 1: downstream ready (FIFO `wready`).
- `out_data_o` out OutW: packed word. Lane k = bits `[k*InW +: InW]`; lane 0 is the first beat.
- `out_mask_o` out Ratio: bit k set means lane k holds a valid beat.
- `busy_o` out 1: high when a partial word is pending or a word is held.

## Operation
- State `st` ∈ {FILL, HOLD}. Registers: `st`, `cnt` (CntW), `data_q` (OutW), `mask_q` (Ratio), `under_rst`.
- `under_rst` is set by reset and clears on the first clock edge after reset release. While it is set, `in_ready_o` = 0 and `out_valid_o` = 0.
- `in_ready_o` = ~under_rst & (st==FILL | out_ready_i). This is a combinational path from `out_ready_i` and is intentional.
- Input accept (`in_valid_i & in_ready_o`):
  - Write the beat into lane `cnt` of `data_q` and set `mask_q[cnt]`.
  - If `cnt==Ratio-1` or `in_last_i`: go to HOLD and set `cnt`=0.
  - Otherwise increment `cnt`.
- `out_valid_o` = (st==HOLD) & ~under_rst. `out_data_o` = `data_q`. `out_mask_o` = `mask_q`.
- Unused lanes of a flushed word read as zero. Lanes are zeroed when a word retires or on clear.
- Output handshake in HOLD (`out_valid_o & out_ready_i`): clear `data_q` and `mask_q`, then go to FILL.
- Simultaneous output handshake and input accept: the retiring word leaves, and the new beat lands in lane 0 with `mask_q`=1 (one-hot).
  - If that beat also has `in_last_i` set, or `Ratio` would be reached, stay in HOLD with the new word.
- `clr_i` has priority over all handshakes: `st`=FILL, `cnt`=0, `data_q`=0, `mask_q`=0. Beats offered in that cycle are not stored, even if `in_ready_o` was high.
- `busy_o` = (st==HOLD) | (mask_q != 0).
- A `in_last_i` with no accepted beat has no effect; `in_last_i` is only sampled on accept.

## Timing
- Reset values: `in_ready_o`=0, `out_valid_o`=0, `out_data_o`=0, `out_mask_o`=0, `busy_o`=0, `st`=FILL.
- Latency: `out_valid_o` rises in the cycle after the completing beat is accepted.
- Throughput: with `out_ready_i` held high, one beat is accepted every cycle with no bubbles. One word is produced every `Ratio` cycles.
- Backpressure: while HOLD and `out_ready_i`=0, `in_ready_o`=0, and `out_data_o`/`out_mask_o` are stable until the handshake.
- `out_valid_o` never drops without a handshake, except on `clr_i` or reset.
- Asserting `rst_ni` low mid-word clears all state immediately. The partial word is lost.

## Structure
- Package `prim_beat_packer_pkg` holds the state enum `packer_st_e` {FILL, HOLD} (2-bit, explicit encoding).
- No sub-module. Integration with the FIFO is done by the parent: `out_valid_o`→`wvalid_i`, `out_data_o`/`out_mask_o`→`wdata_i`.

## Test plan
- Reset release: `in_valid_i`=1 from reset → `in_ready_o`=0 in the first post-reset cycle, then 1. All outputs are 0 during reset.
- Full word, InW=8, Ratio=4: beats 0x11, 0x22, 0x33, 0x44 with ready high → `out_data_o`=0x44332211 and `out_mask_o`=4'b1111, one cycle after the 4th beat.
- Early flush: beats 0xAA, then 0xBB with `in_last_i`=1 → `out_data_o`=0x0000BBAA, `out_mask_o`=4'b0011.
- Backpressure: `out_ready_i`=0 for 5 cycles with a word held → `in_ready_o`=0 and the output is stable. Raising `out_ready_i` lets the word retire and accepts the next beat into lane 0 in the same cycle.
- Streaming: 12 back-to-back beats 0x01..0x0C with constant ready → three words, 0x04030201, 0x08070605, 0x0C0B0A09, with no input stall.
- Clear mid-word: 2 beats, then `clr_i` together with a valid beat → the beat is dropped, `busy_o`=0, and the next 4 beats form a clean word with mask 4'b1111.
